// File: rtl/datapath_pipe.sv
// Two-stage (EX/WB) CPU datapath: register file, ALU, forwarding
// and a req/ack memory port for loads and stores.
module datapath_pipe #(
    parameter int WIDTH = 16,
    parameter int NREG  = 16,
    parameter int PC_W  = 6,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clk_main,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    DR,
    input  logic [AW-1:0]    SA,
    input  logic [AW-1:0]    SB,
    input  logic [3:0]       FS,
    input  logic             MB,
    input  logic             MD,
    input  logic             MW,
    input  logic             MP,
    input  logic             RW,
    input  logic [PC_W-1:0]  PC,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_dr,
    output logic [WIDTH-1:0] wb_data,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    typedef enum logic {
        S_RUN = 1'b0,
        S_MEM = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rf_q [NREG];
    logic             wb_valid_q, wb_valid_d;
    logic [AW-1:0]    wb_dr_q, wb_dr_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [AW-1:0]    ld_dr_q, ld_dr_d;
    logic             ld_wr_q, ld_wr_d;

    logic             accept;
    logic [WIDTH-1:0] a_op, b_rf, b_op;
    logic [WIDTH-1:0] alu_f, bop;
    logic [WIDTH:0]   sum;
    logic             alu_c, alu_v, cin, arith;

    assign in_ready = (state_q == S_RUN);
    assign accept   = in_valid & in_ready;

    // The WB register has not reached the RF yet, so bypass it on a match.
    assign a_op = (wb_valid_q && wb_dr_q == SA) ? wb_data_q : rf_q[SA];
    assign b_rf = (wb_valid_q && wb_dr_q == SB) ? wb_data_q : rf_q[SB];
    assign b_op = MB ? WIDTH'({SA, SB}) : b_rf;

    always_comb begin
        alu_f = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        bop   = '0;
        cin   = 1'b0;
        arith = 1'b0;
        unique case (FS)
            4'h0: alu_f = a_op;
            4'h1: begin arith = 1'b1; cin = 1'b1; end
            4'h2: begin arith = 1'b1; bop = b_op; end
            4'h3: begin arith = 1'b1; bop = b_op; cin = 1'b1; end
            4'h4: begin arith = 1'b1; bop = ~b_op; end
            4'h5: begin arith = 1'b1; bop = ~b_op; cin = 1'b1; end
            4'h6: begin arith = 1'b1; bop = '1; end
            4'h7: alu_f = a_op;
            4'h8: alu_f = a_op & b_op;
            4'h9: alu_f = a_op | b_op;
            4'hA: alu_f = a_op ^ b_op;
            4'hB: alu_f = ~a_op;
            4'hC: alu_f = b_op;
            4'hD: begin
                alu_f = b_op >> 1;
                alu_c = b_op[0];
            end
            4'hE: begin
                alu_f = b_op << 1;
                alu_c = b_op[WIDTH-1];
            end
            4'hF: alu_f = '0;
        endcase
        sum = {1'b0, a_op} + {1'b0, bop} + (WIDTH+1)'(cin);
        if (arith) begin
            alu_f = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a_op[WIDTH-1] == bop[WIDTH-1]) &&
                    (sum[WIDTH-1] != a_op[WIDTH-1]);
        end
    end

    always_comb begin
        state_d     = state_q;
        wb_valid_d  = 1'b0;
        wb_dr_d     = wb_dr_q;
        wb_data_d   = wb_data_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_dr_d     = ld_dr_q;
        ld_wr_d     = ld_wr_q;
        unique case (state_q)
            S_RUN: begin
                if (accept && (MD || MW)) begin
                    state_d     = S_MEM;
                    mem_addr_d  = a_op;
                    mem_wdata_d = b_op;
                    mem_we_d    = MW;
                    ld_dr_d     = DR;
                    ld_wr_d     = MD & ~MW & RW;
                end else if (accept) begin
                    wb_valid_d = RW;
                    wb_dr_d    = DR;
                    wb_data_d  = MP ? WIDTH'(PC) : alu_f;
                    z_d        = (alu_f == '0);
                    n_d        = alu_f[WIDTH-1];
                    c_d        = alu_c;
                    v_d        = alu_v;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = S_RUN;
                    if (ld_wr_q) begin
                        wb_valid_d = 1'b1;
                        wb_dr_d    = ld_dr_q;
                        wb_data_d  = mem_rdata;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RUN;
            wb_valid_q  <= 1'b0;
            wb_dr_q     <= '0;
            wb_data_q   <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_dr_q     <= '0;
            ld_wr_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            wb_dr_q     <= wb_dr_d;
            wb_data_q   <= wb_data_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_dr_q     <= ld_dr_d;
            ld_wr_q     <= ld_wr_d;
            if (wb_valid_q) rf_q[wb_dr_q] <= wb_data_q;
        end
    end

    assign mem_req   = (state_q == S_MEM);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_dr     = wb_dr_q;
    assign wb_data   = wb_data_q;
    assign z         = z_q;
    assign n         = n_q;
    assign c         = c_q;
    assign v         = v_q;

endmodule
